// File: rtl/i2s_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_pkg : shared types and default pin map for the I2S receiver     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_SD_PIN   = 0;
  localparam int DEF_BCLK_PIN = 1;
  localparam int DEF_WS_PIN   = 2;

endpackage
`default_nettype wire

// File: rtl/i2s_rx_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_rx_capture_if : left/right pair valid/ready channel             |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface i2s_rx_capture_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] out_left;
  logic [SAMPLE_W-1:0] out_right;
  logic                out_valid;
  logic                out_ready;

  modport master (output out_left, output out_right, output out_valid, input out_ready);
  modport slave  (input out_left, input out_right, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/pio_pin_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_pin_sync : 2-flop synchroniser plus delay flop edge detect      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module pio_pin_sync (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic pin,
  output logic      sync,
  output logic      rise,
  output logic      fall
);
  logic meta;
  logic sync_q;
  logic dly;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      dly    <= 1'b0;
    end else begin
      meta   <= pin;
      sync_q <= meta;
      dly    <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~dly;
  assign fall = ~sync_q & dly;
endmodule
`default_nettype wire

// File: rtl/i2s_rx_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_rx_capture : oversampling MSB-first I2S deserialiser, L/R pairs |
// | Optional frame counter port under I2S_RX_FRAME_CNT_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SD_PIN   = DEF_SD_PIN,
  parameter int BCLK_PIN = DEF_BCLK_PIN,
  parameter int WS_PIN   = DEF_WS_PIN
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        en,
  input  wire logic [31:0] gpio,
  i2s_rx_capture_if.master out_if,
  output logic             overrun,
  input  wire logic        overrun_clr
`ifdef I2S_RX_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic bclk_sync, bclk_rise, bclk_fall;
  logic sd, sd_rise, sd_fall;
  logic ws, ws_rise, ws_fall;

  pio_pin_sync u_bclk_sync (.clk(clk), .reset_n(reset_n), .pin(gpio[BCLK_PIN]),
                            .sync(bclk_sync), .rise(bclk_rise), .fall(bclk_fall));
  pio_pin_sync u_sd_sync   (.clk(clk), .reset_n(reset_n), .pin(gpio[SD_PIN]),
                            .sync(sd), .rise(sd_rise), .fall(sd_fall));
  pio_pin_sync u_ws_sync   (.clk(clk), .reset_n(reset_n), .pin(gpio[WS_PIN]),
                            .sync(ws), .rise(ws_rise), .fall(ws_fall));

  logic unused_sigs;
  assign unused_sigs = ^{gpio, bclk_sync, bclk_fall, sd_rise, sd_fall, ws_rise, ws_fall};

  state_t              state, state_next;
  logic                ws_prev;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] word, word_next, left_hold;
  logic [SAMPLE_W-1:0] left_q, right_q;
  logic                valid_q;
  logic                ws_edge, latch_left, emit, load, drop;

  assign ws_edge = bclk_rise & (ws != ws_prev);

  // Word with the current bit merged in; the edge bit is the LSB of the ending word.
  always_comb begin
    word_next = word;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (cnt == CNT_W'(SAMPLE_W - 1 - i)) word_next[i] = sd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_left = 1'b0;
    emit       = 1'b0;
    if (!en) begin
      state_next = SYNC;
    end else if (ws_edge) begin
      case (state)
        SYNC:    if (!ws) state_next = LEFT;
        LEFT: begin
          latch_left = 1'b1;
          state_next = RIGHT;
        end
        RIGHT: begin
          emit       = 1'b1;
          state_next = LEFT;
        end
        default: state_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws_prev   <= 1'b0;
      cnt       <= '0;
      word      <= '0;
      left_hold <= '0;
    end else begin
      if (bclk_rise) ws_prev <= ws;
      if (!en) begin
        cnt  <= '0;
        word <= '0;
      end else if (bclk_rise) begin
        if (ws_edge) begin
          cnt  <= '0;
          word <= '0;
        end else begin
          word <= word_next;
          if (cnt < CNT_W'(SAMPLE_W)) cnt <= cnt + CNT_W'(1);
        end
      end
      if (latch_left) left_hold <= word_next;
    end
  end

  // A pending pair blocks new ones unless it is being accepted this cycle.
  assign load = emit & (~valid_q | out_if.out_ready);
  assign drop = emit & valid_q & ~out_if.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        left_q  <= left_hold;
        right_q <= word_next;
        valid_q <= 1'b1;
      end else if (valid_q & out_if.out_ready) begin
        valid_q <= 1'b0;
      end
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

`ifdef I2S_RX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  frame_cnt <= 16'd0;
    else if (load) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

  assign out_if.out_left  = left_q;
  assign out_if.out_right = right_q;
  assign out_if.out_valid = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2s_rx_capture : directed I2S frames with hand-computed pairs    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_i2s_rx_capture;
  localparam int SD   = 0;
  localparam int BCLK = 1;
  localparam int WS   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [31:0] gpio;
  logic        overrun;
  logic        overrun_clr;
`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  i2s_rx_capture_if #(.SAMPLE_W(16)) bus ();

  i2s_rx_capture #(.SAMPLE_W(16), .SD_PIN(SD), .BCLK_PIN(BCLK), .WS_PIN(WS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .gpio       (gpio),
    .out_if     (bus.master),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef I2S_RX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int half   = 4;
  int acc_cnt = 0;
  int a0;
  logic [15:0] last_l, last_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Records every accepted pair, sampled after inputs have settled.
  always @(negedge clk) begin
    #1;
    if (bus.out_valid && bus.out_ready) begin
      acc_cnt++;
      last_l = bus.out_left;
      last_r = bus.out_right;
    end
  end

  task automatic slot(input logic ws_v, input logic sd_v);
    @(negedge clk);
    gpio[BCLK] = 1'b0;
    gpio[WS]   = ws_v;
    gpio[SD]   = sd_v;
    repeat (half) @(negedge clk);
    gpio[BCLK] = 1'b1;
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic sync_pre();
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
  endtask

  // Left bits with ws=0 (LSB with ws=1), right bits with ws=1 (LSB with ws=0).
  task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r,
                            input int nr, input bit chk_lat, input bit do_clr);
    for (int i = nl - 1; i >= 1; i--) slot(1'b0, l[i]);
    slot(1'b1, l[0]);
    for (int i = nr - 1; i >= 1; i--) slot(1'b1, r[i]);
    @(negedge clk);
    gpio[BCLK] = 1'b0;
    gpio[WS]   = 1'b0;
    gpio[SD]   = r[0];
    repeat (half) @(negedge clk);
    gpio[BCLK] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (chk_lat) check("lat_edge2_valid", {31'd0, bus.out_valid}, 32'd0);
    if (do_clr) overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    if (chk_lat) check("lat_edge3_valid", {31'd0, bus.out_valid}, 32'd1);
    repeat (half - 3) @(negedge clk);
  endtask

  task automatic check_pair(input string tag, input int n, input logic [15:0] l,
                            input logic [15:0] r);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, acc_cnt - a0, n);
    check({tag, "_left"}, {16'd0, last_l}, {16'd0, l});
    check({tag, "_right"}, {16'd0, last_r}, {16'd0, r});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    en = 1'b1;
    gpio = 32'd0;
    overrun_clr = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_left", {16'd0, bus.out_left}, 32'd0);
    check("rst_right", {16'd0, bus.out_right}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;

    // Basic frame with latency check
    sync_pre();
    a0 = acc_cnt;
    send_frame(32'hA55A, 16, 32'h0F0F, 16, 1'b1, 1'b0);
    check_pair("basic", 1, 16'hA55A, 16'h0F0F);
    check("basic_overrun", {31'd0, overrun}, 32'd0);

    // Slower bit clock, all-ones then all-zeros
    half = 8;
    a0 = acc_cnt;
    send_frame(32'hFFFF, 16, 32'h0000, 16, 1'b0, 1'b0);
    check_pair("ones_zeros", 1, 16'hFFFF, 16'h0000);
    half = 4;

    a0 = acc_cnt;
    send_frame(32'hABC, 12, 32'h123, 12, 1'b0, 1'b0);
    check_pair("short", 1, 16'hABC0, 16'h1230);

    a0 = acc_cnt;
    send_frame(32'hFEDCB, 20, 32'h12345, 20, 1'b0, 1'b0);
    check_pair("long", 1, 16'hFEDC, 16'h1234);

    // Back-pressure and overrun
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    send_frame(32'h1111, 16, 32'h2222, 16, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("bp1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp1_left", {16'd0, bus.out_left}, 32'h1111);
    check("bp1_overrun", {31'd0, overrun}, 32'd0);
    send_frame(32'h3333, 16, 32'h4444, 16, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("bp2_overrun", {31'd0, overrun}, 32'd1);
    check("bp2_left", {16'd0, bus.out_left}, 32'h1111);
    check("bp2_right", {16'd0, bus.out_right}, 32'h2222);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    @(negedge clk);
    check("clr_overrun", {31'd0, overrun}, 32'd0);
    send_frame(32'h5555, 16, 32'h6666, 16, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("setwins_overrun", {31'd0, overrun}, 32'd1);
    check("bp3_left", {16'd0, bus.out_left}, 32'h1111);
    check("bp3_right", {16'd0, bus.out_right}, 32'h2222);
`ifdef I2S_RX_FRAME_CNT_EN
    check("frame_cnt_drops", {16'd0, frame_cnt}, 32'd5);
`endif
    bus.out_ready = 1'b1;
    check_pair("drain", 1, 16'h1111, 16'h2222);
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a left word
    for (int i = 0; i < 5; i++) slot(1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_left", {16'd0, bus.out_left}, 32'd0);
    check("midrst_right", {16'd0, bus.out_right}, 32'd0);
    check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 3; i++) slot(1'b1, 1'b1);
    slot(1'b0, 1'b1);
    send_frame(32'h7777, 16, 32'h8888, 16, 1'b0, 1'b0);
    check_pair("post_rst", 1, 16'h7777, 16'h8888);

    // Enable low mid-word forces resynchronisation
    for (int i = 0; i < 4; i++) slot(1'b0, 1'b1);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 2; i++) slot(1'b1, 1'b1);
    slot(1'b0, 1'b0);
    send_frame(32'h9999, 16, 32'hAAAA, 16, 1'b0, 1'b0);
    check_pair("en_resync", 1, 16'h9999, 16'hAAAA);
`ifdef I2S_RX_FRAME_CNT_EN
    check("frame_cnt_after_rst", {16'd0, frame_cnt}, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/i2s_rx_capture.md
Name: i2s_rx_capture

Overview:
- Downstream consumer of the PIO I2S transmitter program.
- Watches the PIO gpio_out pins (serial data, bit clock, word select), oversamples them in the system clock domain and deserialises MSB-first I2S words.
- Presents each completed left/right pair on a valid/ready interface.
- Used as the on-chip loopback checker for the PIO I2S program and as the receive front end for I2S capture.

Parameters:
- SAMPLE_W, 16: bits per channel word delivered on the output.
- SD_PIN, 0: gpio index carrying serial data.
- BCLK_PIN, 1: gpio index carrying the bit clock (sideset bit 0).
- WS_PIN, 2: gpio index carrying word select / LRCLK (sideset bit 1).

Ports:
- clk  in  1  system clock; pins are oversampled (bclk must be at most clk/4).
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable; low forces the SYNC state.
- gpio  in  32  PIO gpio_out bus.
- out_left  out  SAMPLE_W  left word (ws=0).
- out_right  out  SAMPLE_W  right word (ws=1).
- out_valid  out  1  pair available.
- out_ready  in  1  consumer accepts the pair.
- overrun  out  1  sticky: a pair was dropped.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (reset_n).
- Reset values: out_left=0, out_right=0, out_valid=0, overrun=0, state=SYNC, shift word=0, bit count=0, synchronisers=0.
- Input sampling: gpio[BCLK_PIN], gpio[WS_PIN] and gpio[SD_PIN] each pass through a 2-flop synchroniser plus a delay flop.
- bclk_rise = sync & ~delayed. All capture actions happen only in cycles where bclk_rise=1.
- sd and ws values used are the synchronised values in that same cycle.
- Per bclk_rise:
  - ws_edge = (ws != ws_prev); ws_prev is then updated to ws.
  - If cnt < SAMPLE_W: word[SAMPLE_W-1-cnt] <= sd. Otherwise the bit is dropped (long words truncated to their first SAMPLE_W bits).
  - cnt saturates at SAMPLE_W.
  - Short words are left-justified with zero fill.
- ws_edge rule (I2S one-bit delay): the bit sampled on the edge where ws changes is the LSB of the word ending for channel ws_prev. It is written into that word first, then the word is completed, cleared to 0, and cnt reset to 0.
- State machine:
  - SYNC: on ws_edge with new ws=0 (falling), go to LEFT. Any partial word is discarded.
  - LEFT: on ws_edge (0->1), latch the completed word into left_hold, go to RIGHT.
  - RIGHT: on ws_edge (1->0), present {left_hold, completed word} as a pair, go to LEFT.
  - en=0 in any state: go to SYNC, clear cnt and word, next cycle. out_valid and held outputs are unaffected.
- Output handshake:
  - A pair is accepted in a cycle where out_valid & out_ready.
  - out_valid, out_left and out_right update on the clk edge after the completing bclk_rise. Latency is 3 clk edges after the first clk edge that samples bclk high at the pin.
  - out_left and out_right are stable while out_valid=1.
  - New pair while out_valid=0, or in the same cycle as acceptance: load it; out_valid=1.
  - New pair while out_valid=1 & !out_ready: drop the new pair, keep the old one, set overrun=1.
  - overrun_clr in the same cycle as a new overrun event: set wins.
- reset_n asserted mid-word: all state is cleared immediately. After release, the block waits for a falling ws edge.

Optional Feature:
- Macro: I2S_RX_FRAME_CNT_EN.
- Defined: adds output port frame_cnt[15:0], reset to 0. It increments on every pair loaded into the output register, wraps 0xFFFF -> 0, and does not count dropped pairs.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package i2s_pkg: state enum typedef (SYNC, LEFT, RIGHT), default pin-index constants, default SAMPLE_W.
- Sub-module pio_pin_sync: 2-flop synchroniser plus rise/fall detect. Instantiated three times, reusable for other PIO pin monitors.

Test Plan:
- Synthetic frame, bclk = clk/8, left=16'hA55A, right=16'h0F0F, out_ready=1 -> exactly one out_valid pulse with out_left=A55A and out_right=0F0F; overrun=0.
- PIO I2S program (div 0x0100, pins 0/1/2) with TX push 32'hFFFF0000 -> first pair out_left=FFFF, out_right=0000.
- out_ready=0 across two complete frames (L=1111/R=2222 then L=3333/R=4444) -> outputs hold 1111/2222 and overrun=1. Then overrun_clr with a new overrun in the same cycle -> overrun stays 1.
- 12-bit words L=0xABC, R=0x123 -> out_left=ABC0, out_right=1230. 20-bit words L=0xFEDCB -> out_left=FEDC.
- Start mid-right-channel, then pulse reset_n low mid-left-word -> all outputs 0. The first pair after reset is the first complete frame following a ws falling edge; no partial pair is emitted.
- With I2S_RX_FRAME_CNT_EN: 3 frames accepted plus 1 dropped -> frame_cnt=3. Preset near wrap -> 0xFFFF followed by 0x0000.
